can_arbitration_rx: RTL

//  Bit-level front end of the CAN decoder's identifier path. Consumes sampled bus bits at each

---
 rtl/can_arbitration_rx_pkg.sv | 21 ++
 rtl/can_arbitration_rx_if.sv | 25 ++
 rtl/can_arbitration_rx_destuffer.sv | 48 ++++
 rtl/can_arbitration_rx.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/can_arbitration_rx_pkg.sv
// Shared types and widths for the CAN identifier receive path.
package can_arbitration_rx_pkg;

  localparam int unsigned ID_BASE_W       = 11;
  localparam int unsigned ID_EXT_W        = 18;
  localparam int unsigned STUFF_LIMIT_DEF = 5;
  localparam int unsigned IDLE_BITS_DEF   = 11;
  localparam int unsigned CNT_W           = 5;

  typedef enum logic [2:0] {
    StIdle,
    StBase,
    StSrrRtr,
    StIdeBit,
    StExt,
    StRtrExt,
    StTail,
    StErr
  } state_e;

endpackage

// File: rtl/can_arbitration_rx_if.sv
// Bit-stream input and decoded-identifier output bundle of the CAN identifier front end.
interface can_arbitration_rx_if;
  import can_arbitration_rx_pkg::*;

  logic                 sp;
  logic                 rx_bit;
  logic [ID_BASE_W-1:0] id_base;
  logic [ID_EXT_W-1:0]  id_ext;
  logic                 ide;
  logic                 rtr;
  logic                 id_valid;
  logic                 f_idf;
  logic                 stuff_err;

  modport master (
    output sp, rx_bit,
    input  id_base, id_ext, ide, rtr, id_valid, f_idf, stuff_err
  );

  modport slave (
    input  sp, rx_bit,
    output id_base, id_ext, ide, rtr, id_valid, f_idf, stuff_err
  );

endinterface

// File: rtl/can_arbitration_rx_destuffer.sv
// Tracks the last bit and run length of the stuffed stream; flags stuff bits and violations.
module can_arbitration_rx_destuffer #(
  parameter int unsigned STUFF_LIMIT = 5
) (
  input  logic clk,
  input  logic reset,
  input  logic sp,
  input  logic rx_bit,
  input  logic enable,
  input  logic seed,
  output logic data_en,
  output logic stuff_err
);

  localparam int unsigned RunW = $clog2(STUFF_LIMIT + 1);
  localparam logic [RunW-1:0] RunMax = RunW'(STUFF_LIMIT);

  logic            last_q;
  logic [RunW-1:0] run_q;
  logic            is_stuff;

  always_comb begin
    is_stuff  = (run_q == RunMax);
    data_en   = sp && enable && !is_stuff;
    stuff_err = sp && enable && is_stuff && (rx_bit == last_q);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_q <= 1'b0;
      run_q  <= '0;
    end else if (sp) begin
      if (seed) begin
        // SOF is dominant and counts as the first bit of the run.
        last_q <= 1'b0;
        run_q  <= RunW'(1);
      end else if (enable) begin
        if (rx_bit != last_q) begin
          last_q <= rx_bit;
          run_q  <= RunW'(1);
        end else if (!is_stuff) begin
          run_q <= run_q + RunW'(1);
        end
      end
    end
  end

endmodule

// File: rtl/can_arbitration_rx.sv
// CAN arbitration-field receiver: SOF detection, destuffing and identifier/IDE/RTR capture.
module can_arbitration_rx
  import can_arbitration_rx_pkg::*;
#(
  parameter int unsigned IDLE_BITS   = IDLE_BITS_DEF,
  parameter int unsigned STUFF_LIMIT = STUFF_LIMIT_DEF
) (
  input logic                 clk,
  input logic                 reset,
  can_arbitration_rx_if.slave bus
);

  localparam int unsigned IdleW = $clog2(IDLE_BITS + 1);
  localparam logic [IdleW-1:0] IdleMax  = IdleW'(IDLE_BITS);
  localparam logic [IdleW-1:0] IdleLast = IdleW'(IDLE_BITS - 1);
  localparam logic [CNT_W-1:0] BaseLast = CNT_W'(ID_BASE_W - 1);
  localparam logic [CNT_W-1:0] ExtLast  = CNT_W'(ID_EXT_W - 1);

  state_e               state_q;
  logic [IdleW-1:0]     idle_cnt_q;
  logic [CNT_W-1:0]     shift_cnt_q;
  logic [ID_BASE_W-1:0] base_sr_q;
  logic [ID_EXT_W-1:0]  ext_sr_q;
  logic                 rtr_tmp_q;

  logic [ID_BASE_W-1:0] id_base_q;
  logic [ID_EXT_W-1:0]  id_ext_q;
  logic                 ide_q, rtr_q, id_valid_q, f_idf_q, stuff_err_q;

  logic ds_enable, ds_seed, data_en, ds_err;

  always_comb begin
    ds_enable = (state_q == StBase) || (state_q == StSrrRtr) || (state_q == StIdeBit) ||
                (state_q == StExt)  || (state_q == StRtrExt);
    ds_seed   = (state_q == StIdle) && !bus.rx_bit && (idle_cnt_q >= IdleMax);
  end

  can_arbitration_rx_destuffer #(
    .STUFF_LIMIT (STUFF_LIMIT)
  ) u_destuffer (
    .clk       (clk),
    .reset     (reset),
    .sp        (bus.sp),
    .rx_bit    (bus.rx_bit),
    .enable    (ds_enable),
    .seed      (ds_seed),
    .data_en   (data_en),
    .stuff_err (ds_err)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      idle_cnt_q  <= '0;
      shift_cnt_q <= '0;
      base_sr_q   <= '0;
      ext_sr_q    <= '0;
      rtr_tmp_q   <= 1'b0;
      id_base_q   <= '0;
      id_ext_q    <= '0;
      ide_q       <= 1'b0;
      rtr_q       <= 1'b0;
      id_valid_q  <= 1'b0;
      f_idf_q     <= 1'b1;
      stuff_err_q <= 1'b0;
    end else begin
      id_valid_q  <= 1'b0;
      stuff_err_q <= 1'b0;
      if (bus.sp) begin
        f_idf_q <= 1'b1;
        unique case (state_q)
          StIdle: begin
            if (bus.rx_bit) begin
              if (idle_cnt_q < IdleMax) idle_cnt_q <= idle_cnt_q + IdleW'(1);
            end else if (idle_cnt_q >= IdleMax) begin
              state_q     <= StBase;
              shift_cnt_q <= '0;
              idle_cnt_q  <= '0;
            end else begin
              idle_cnt_q <= '0;
            end
          end
          StBase, StSrrRtr, StIdeBit, StExt, StRtrExt: begin
            if (ds_err) begin
              stuff_err_q <= 1'b1;
              state_q     <= StErr;
              idle_cnt_q  <= '0;
            end else if (data_en) begin
              unique case (state_q)
                StBase: begin
                  base_sr_q   <= {base_sr_q[ID_BASE_W-2:0], bus.rx_bit};
                  shift_cnt_q <= shift_cnt_q + CNT_W'(1);
                  if (shift_cnt_q == BaseLast) state_q <= StSrrRtr;
                end
                StSrrRtr: begin
                  rtr_tmp_q <= bus.rx_bit;
                  state_q   <= StIdeBit;
                end
                StIdeBit: begin
                  if (bus.rx_bit) begin
                    state_q     <= StExt;
                    shift_cnt_q <= '0;
                  end else begin
                    id_base_q  <= base_sr_q;
                    id_ext_q   <= '0;
                    ide_q      <= 1'b0;
                    rtr_q      <= rtr_tmp_q;
                    id_valid_q <= 1'b1;
                    f_idf_q    <= 1'b0;
                    state_q    <= StTail;
                    idle_cnt_q <= '0;
                  end
                end
                StExt: begin
                  ext_sr_q    <= {ext_sr_q[ID_EXT_W-2:0], bus.rx_bit};
                  shift_cnt_q <= shift_cnt_q + CNT_W'(1);
                  if (shift_cnt_q == ExtLast) state_q <= StRtrExt;
                end
                default: begin
                  id_base_q  <= base_sr_q;
                  id_ext_q   <= ext_sr_q;
                  ide_q      <= 1'b1;
                  rtr_q      <= bus.rx_bit;
                  id_valid_q <= 1'b1;
                  f_idf_q    <= 1'b0;
                  state_q    <= StTail;
                  idle_cnt_q <= '0;
                end
              endcase
            end
          end
          StTail, StErr: begin
            // Leave with the counter saturated so the next dominant bit is a valid SOF.
            if (bus.rx_bit) begin
              idle_cnt_q <= idle_cnt_q + IdleW'(1);
              if (idle_cnt_q == IdleLast) state_q <= StIdle;
            end else begin
              idle_cnt_q <= '0;
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  assign bus.id_base   = id_base_q;
  assign bus.id_ext    = id_ext_q;
  assign bus.ide       = ide_q;
  assign bus.rtr       = rtr_q;
  assign bus.id_valid  = id_valid_q;
  assign bus.f_idf     = f_idf_q;
  assign bus.stuff_err = stuff_err_q;

endmodule
